// File: rtl/tune_pkg.sv
// Shared widths, frame geometry and loader state type for the SPI tune loader and the tune player.
package tune_pkg;
  localparam int NUM_NOTES   = 6;
  localparam int NOTE_W      = 8;
  localparam int SPEED_BYTES = 5;
  localparam int SPEED_W     = 36;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME_BITS  = NUM_NOTES * NOTE_W + SPEED_BYTES * 8;
  localparam int CNT_W       = 7;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    PLAY  = 2'd3
  } loader_state_t;

  // A frame is usable only with exactly FRAME_BITS bits and a non-zero divisor.
  function automatic logic frame_valid(input logic [CNT_W-1:0] count,
                                       input logic [SPEED_W-1:0] speed);
    return (count == CNT_FULL) && (speed != {SPEED_W{1'b0}});
  endfunction
endpackage

// File: rtl/spi_tune_loader_if.sv
// MCU-side SPI pins plus the parameter/start bundle handed to the tune player.
interface spi_tune_loader_if;
  import tune_pkg::*;

  logic               sclk;
  logic               sdi;
  logic               load;
  logic [NOTE_W-1:0]  sd0;
  logic [NOTE_W-1:0]  sd1;
  logic [NOTE_W-1:0]  sd2;
  logic [NOTE_W-1:0]  sd3;
  logic [NOTE_W-1:0]  sd4;
  logic [NOTE_W-1:0]  sd5;
  logic [SPEED_W-1:0] clockSpeed;
  logic               start;
  logic               frame_err;

  modport slave (
    input  sclk, sdi, load,
    output sd0, sd1, sd2, sd3, sd4, sd5, clockSpeed, start, frame_err
  );

  modport master (
    output sclk, sdi, load,
    input  sd0, sd1, sd2, sd3, sd4, sd5, clockSpeed, start, frame_err
  );
endinterface

// File: rtl/spi_tune_loader_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with one-cycle rise/fall pulses.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // Synchronizer chain (STAGES >= 2) plus the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_r <= {STAGES{1'b0}};
      prev_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign q    = chain_r[STAGES-1];
  assign rise = q & ~prev_r;
  assign fall = ~q & prev_r;
endmodule

// File: rtl/spi_tune_loader.sv
// SPI slave that collects an 88-bit song frame and publishes it to the tune player
// only after the frame has been checked, holding the parameters stable while start is high.
module spi_tune_loader
  import tune_pkg::*;
(
  input logic              clk,
  input logic              reset,
  spi_tune_loader_if.slave bus
);
  logic                   sclk_q, sclk_rise, sclk_fall;
  logic                   load_q, load_rise, load_fall;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic                   sdi_q;
  loader_state_t          state_r, state_s;
  logic [CNT_W-1:0]       count_r;
  logic [FRAME_BITS-1:0]  shreg_r;
  logic                   count_en_s, valid_s, enter_shift_s;
  logic                   unused_bits_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(bus.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk(clk), .reset(reset), .d(bus.load), .q(load_q), .rise(load_rise), .fall(load_fall)
  );

  // The divisor's top nibble on the wire is deliberately discarded.
  assign unused_bits_s = ^{sclk_q, sclk_fall, shreg_r[SPEED_BYTES*8-1:SPEED_W]};

  // sdi takes the same depth as sclk so the sampled bit lines up with the detected rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], bus.sdi};
    end
  end

  assign sdi_q         = sdi_sync_r[SYNC_STAGES-1];
  assign count_en_s    = sclk_rise & load_q;
  assign valid_s       = frame_valid(count_r, shreg_r[SPEED_W-1:0]);
  assign enter_shift_s = (state_r != SHIFT) && (state_s == SHIFT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (load_rise) state_s = SHIFT; else state_s = IDLE;
      SHIFT:   if (load_fall) state_s = CHECK; else state_s = SHIFT;
      CHECK:   if (valid_s)   state_s = PLAY;  else state_s = IDLE;
      PLAY:    if (load_rise) state_s = SHIFT; else state_s = PLAY;
      default: state_s = IDLE;
    endcase
  end

  // Bit counter saturates one past a full frame so overlong frames stay detectable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
      shreg_r <= {FRAME_BITS{1'b0}};
    end else if (enter_shift_s) begin
      count_r <= {CNT_W{1'b0}};
      shreg_r <= {FRAME_BITS{1'b0}};
    end else if ((state_r == SHIFT) && count_en_s) begin
      if (count_r != CNT_SAT) begin
        count_r <= count_r + CNT_W'(1);
      end
      shreg_r <= {shreg_r[FRAME_BITS-2:0], sdi_q};
    end
  end

  // Player-facing registers: parameters move only on a validated frame, start follows PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sd0        <= {NOTE_W{1'b0}};
      bus.sd1        <= {NOTE_W{1'b0}};
      bus.sd2        <= {NOTE_W{1'b0}};
      bus.sd3        <= {NOTE_W{1'b0}};
      bus.sd4        <= {NOTE_W{1'b0}};
      bus.sd5        <= {NOTE_W{1'b0}};
      bus.clockSpeed <= {SPEED_W{1'b0}};
      bus.start      <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.start <= (state_s == PLAY);
      if (state_r == CHECK) begin
        if (valid_s) begin
          bus.sd0        <= shreg_r[FRAME_BITS-1            -: NOTE_W];
          bus.sd1        <= shreg_r[FRAME_BITS-1-  NOTE_W   -: NOTE_W];
          bus.sd2        <= shreg_r[FRAME_BITS-1-2*NOTE_W   -: NOTE_W];
          bus.sd3        <= shreg_r[FRAME_BITS-1-3*NOTE_W   -: NOTE_W];
          bus.sd4        <= shreg_r[FRAME_BITS-1-4*NOTE_W   -: NOTE_W];
          bus.sd5        <= shreg_r[FRAME_BITS-1-5*NOTE_W   -: NOTE_W];
          bus.clockSpeed <= shreg_r[SPEED_W-1:0];
          bus.frame_err  <= 1'b0;
        end else begin
          bus.frame_err  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_tune_loader.sv
// Directed bench for spi_tune_loader: a frame-level model predicts the player outputs and a
// per-cycle compare process checks them, with literal pins on the hand-computed frames.
module tb_spi_tune_loader;
  import tune_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_tune_loader_if bus ();
  spi_tune_loader dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  logic [NOTE_W-1:0]  exp_sd [NUM_NOTES];
  logic [SPEED_W-1:0] exp_speed = '0;
  logic               exp_start = 1'b0;
  logic               exp_err = 1'b0;
  bit                 data_chk = 1'b0;
  bit                 start_chk = 1'b0;

  logic [NUM_NOTES*NOTE_W-1:0]         dut_notes;
  logic [NUM_NOTES*NOTE_W+SPEED_W-1:0] cur_out, prev_out;
  logic                                prev_start = 1'b0;

  assign dut_notes = {bus.sd0, bus.sd1, bus.sd2, bus.sd3, bus.sd4, bus.sd5};
  assign cur_out   = {dut_notes, bus.clockSpeed};

  localparam logic [FRAME_BITS-1:0] F1 = 88'h05_0A_08_0F_05_05_00_00_00_00_14;
  localparam logic [FRAME_BITS-1:0] F2 = 88'h11_22_33_44_55_66_00_00_00_00_99;
  localparam logic [FRAME_BITS-1:0] F3 = 88'h01_02_03_04_05_06_F0_00_00_00_01;
  localparam logic [FRAME_BITS-1:0] F4 = 88'hAA_BB_CC_DD_EE_FF_F0_00_00_00_00;
  localparam logic [FRAME_BITS-1:0] F5 = 88'h01_20_30_40_50_60_00_00_00_01_00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level rule: accept exactly 88 bits with a non-zero low 36-bit divisor.
  task automatic model_frame(input logic [FRAME_BITS-1:0] f, input int nbits);
    if (nbits == FRAME_BITS && f[SPEED_W-1:0] != '0) begin
      for (int i = 0; i < NUM_NOTES; i++) exp_sd[i] = f[FRAME_BITS-1-NOTE_W*i -: NOTE_W];
      exp_speed = f[SPEED_W-1:0];
      exp_err   = 1'b0;
      exp_start = 1'b1;
    end else begin
      exp_err   = 1'b1;
      exp_start = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_NOTES; i++) exp_sd[i] = '0;
    exp_speed = '0;
    exp_err   = 1'b0;
    exp_start = 1'b0;
  endtask

  // Per-cycle comparison against the model, plus output stability while start is high.
  always @(negedge clk) begin
    if (data_chk) begin
      for (int i = 0; i < NUM_NOTES; i++)
        check($sformatf("sd%0d", i), dut_notes[NUM_NOTES*NOTE_W-1-NOTE_W*i -: NOTE_W], exp_sd[i]);
      check("clockSpeed", bus.clockSpeed, exp_speed);
      check("frame_err", bus.frame_err, exp_err);
    end
    if (start_chk) check("start", bus.start, exp_start);
    if (!reset && prev_start === 1'b1 && bus.start === 1'b1)
      check("params_held_while_start", cur_out, prev_out);
    prev_out   <= cur_out;
    prev_start <= bus.start & ~reset;
  end

  // One sclk half period of 4 or 5 clk, edges placed 3 ns after a clk rise.
  task automatic half();
    int k;
    k = 4 + $urandom_range(0, 1);
    repeat (k) @(posedge clk);
    #3;
  endtask

  task automatic send_bits(input logic [FRAME_BITS-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sdi = (i < FRAME_BITS) ? f[FRAME_BITS-1-i] : 1'b0;
      half();
      bus.sclk = 1'b1;
      half();
      bus.sclk = 1'b0;
    end
  endtask

  task automatic start_frame();
    int k;
    start_chk = 1'b0;
    half();
    bus.load = 1'b1;
    exp_start = 1'b0;
    k = 0;
    while (bus.start !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("start_drop_within_bound", (k <= SYNC_STAGES + 2), 1'b1);
    half();
    start_chk = 1'b1;
  endtask

  task automatic end_frame(input logic [FRAME_BITS-1:0] f, input int n);
    int k;
    half();
    data_chk  = 1'b0;
    start_chk = 1'b0;
    bus.load  = 1'b0;
    model_frame(f, n);
    if (exp_start) begin
      k = 0;
      while (bus.start !== 1'b1 && k < 12) begin
        @(negedge clk);
        k++;
      end
      check("start_rise_within_bound", (k <= SYNC_STAGES + 3), 1'b1);
    end else begin
      repeat (SYNC_STAGES + 4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #1;
    data_chk  = 1'b1;
    start_chk = 1'b1;
  endtask

  task automatic frame(input logic [FRAME_BITS-1:0] f, input int n);
    start_frame();
    send_bits(f, n);
    end_frame(f, n);
  endtask

  task automatic pin_test1(input string tag);
    check({tag, "_sd0"}, bus.sd0, 8'd5);
    check({tag, "_sd1"}, bus.sd1, 8'd10);
    check({tag, "_sd2"}, bus.sd2, 8'd8);
    check({tag, "_sd3"}, bus.sd3, 8'd15);
    check({tag, "_sd4"}, bus.sd4, 8'd5);
    check({tag, "_sd5"}, bus.sd5, 8'd5);
    check({tag, "_speed"}, bus.clockSpeed, 36'd20);
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.sdi  = 1'b0;
    bus.load = 1'b0;
    model_reset();
    #3 reset = 1'b1;
    #2;
    check("rst_notes", dut_notes, 48'd0);
    check("rst_speed", bus.clockSpeed, 36'd0);
    check("rst_start", bus.start, 1'b0);
    check("rst_err", bus.frame_err, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    data_chk  = 1'b1;
    start_chk = 1'b1;
    repeat (4) @(posedge clk);

    // Test 1: baseline frame.
    frame(F1, FRAME_BITS);
    pin_test1("t1");
    check("t1_start", bus.start, 1'b1);
    check("t1_err", bus.frame_err, 1'b0);

    // sclk activity with load low must be ignored while playing.
    for (int i = 0; i < 6; i++) begin
      bus.sdi = i[0];
      half();
      bus.sclk = ~bus.sclk;
    end
    bus.sclk = 1'b0;
    check("idle_sclk_start", bus.start, 1'b1);

    // Test 2: one bit short.
    frame(F2, FRAME_BITS - 1);
    pin_test1("t2");
    check("t2_err", bus.frame_err, 1'b1);
    check("t2_start", bus.start, 1'b0);

    // Test 3: top nibble of the divisor is ignored.
    frame(F3, FRAME_BITS);
    check("t3_speed", bus.clockSpeed, 36'h0_0000_0001);
    check("t3_sd5", bus.sd5, 8'h06);
    check("t3_err", bus.frame_err, 1'b0);

    // Test 4: divisor zero in its low 36 bits.
    frame(F4, FRAME_BITS);
    check("t4_err", bus.frame_err, 1'b1);
    check("t4_start", bus.start, 1'b0);
    check("t4_speed", bus.clockSpeed, 36'h0_0000_0001);

    // Zero-bit and overlong frames.
    frame(F1, 0);
    check("zero_bits_err", bus.frame_err, 1'b1);
    frame(F2, FRAME_BITS + 1);
    check("overlong_err", bus.frame_err, 1'b1);
    check("overlong_sd0", bus.sd0, 8'h01);

    // Test 5: re-load while playing.
    frame(F3, FRAME_BITS);
    check("t5_pre_start", bus.start, 1'b1);
    frame(F5, FRAME_BITS);
    check("t5_start", bus.start, 1'b1);
    check("t5_sd0", bus.sd0, 8'd1);
    check("t5_speed", bus.clockSpeed, 36'h100);

    // Test 6: reset in the middle of a frame.
    start_frame();
    send_bits(F1, 40);
    data_chk  = 1'b0;
    start_chk = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    bus.load = 1'b0;
    bus.sclk = 1'b0;
    model_reset();
    #1;
    check("t6_rst_notes", dut_notes, 48'd0);
    check("t6_rst_speed", bus.clockSpeed, 36'd0);
    check("t6_rst_start", bus.start, 1'b0);
    check("t6_rst_err", bus.frame_err, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    data_chk  = 1'b1;
    start_chk = 1'b1;
    frame(F1, FRAME_BITS);
    pin_test1("t6");
    check("t6_start", bus.start, 1'b1);
    check("t6_err", bus.frame_err, 1'b0);

    repeat (4) @(posedge clk);
    data_chk  = 1'b0;
    start_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
